icache_line_assembler: RTL and testbench

//  Collects response beats from the fta bus into full I$ lines for up to SLOTS outstanding fills.

---
 rtl/icache_line_assembler.sv | 244 ++++++++++++++++++++++++
 tb/tb_icache_line_assembler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_assembler.sv
// icache_line_assembler
//   Gathers interleaved, out-of-order response beats into complete I$ lines
//   for up to SLOTS outstanding fills. Each complete line is handed to the
//   cache write port through a valid/ready output register, together with a
//   pseudo-random victim way.
//   Optional feature macro: ICACHE_ACK_ERR_EN (bus-error tracking per slot).
module icache_line_assembler #(
  parameter int LOG_WAYS     = 2,
  parameter int BEATS        = 2,
  parameter int BEAT_W       = 256,
  parameter int SLOTS        = 2,
  parameter int TID_W        = 4,
  parameter int TID_SLOT_LSB = 2,
  parameter int ADR_W        = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          resp_ack,
  input  logic [TID_W-1:0]              resp_tid,
  input  logic [ADR_W-1:0]              resp_adr,
  input  logic [BEAT_W-1:0]             resp_dat,
  input  logic                          resp_err,
  input  logic [(2**TID_W)*ADR_W-1:0]   vtags,
  output logic                          wr_ic,
  input  logic                          wr_rdy,
  output logic [ADR_W-1:0]              line_vtag,
  output logic [ADR_W-1:0]              line_ptag,
  output logic [BEATS*BEAT_W-1:0]       line_data,
  output logic                          line_err,
  output logic [LOG_WAYS-1:0]           way,
  output logic                          dup_beat,
  output logic [SLOTS-1:0]              slot_busy
);

  // Derived widths. SLOTS and BEATS are assumed to be at least 2 so the
  // slot and beat index fields are never zero width.
  localparam int LOG_BEATS = $clog2(BEATS);
  localparam int BEAT_B    = $clog2(BEAT_W / 8);
  localparam int LOG_SLOTS = $clog2(SLOTS);
  localparam int LINE_B    = $clog2(BEATS * BEAT_W / 8);
  localparam int LINE_W    = BEATS * BEAT_W;

  // Byte-offset-within-line mask; tags are presented with these bits zero.
  localparam logic [ADR_W-1:0] LMASK = ADR_W'((64'd1 << LINE_B) - 64'd1);

  // ---------------------------------------------------------------------
  // Slot storage
  // ---------------------------------------------------------------------
  logic [BEATS-1:0]     r_v     [SLOTS];
  logic [LINE_W-1:0]    r_data  [SLOTS];
  logic [ADR_W-1:0]     r_vtag  [SLOTS];
  logic [ADR_W-1:0]     r_ptag  [SLOTS];
  logic [LOG_SLOTS-1:0] r_rr;
  logic [16:0]          r_lfsr;

  // Output register
  logic                 r_wr_ic;
  logic [ADR_W-1:0]     r_line_vtag;
  logic [ADR_W-1:0]     r_line_ptag;
  logic [LINE_W-1:0]    r_line_data;
  logic                 r_line_err;
  logic [LOG_WAYS-1:0]  r_way;
  logic                 r_dup;

  // Incoming beat decode
  logic [LOG_SLOTS-1:0] w_slot;
  logic [LOG_BEATS-1:0] w_bi;
  logic                 w_hit_valid;
  logic                 w_accept;
  logic [ADR_W-1:0]     w_beat_vtag;
  logic [ADR_W-1:0]     w_beat_ptag;

  assign w_slot      = resp_tid[TID_SLOT_LSB +: LOG_SLOTS];
  assign w_bi        = resp_adr[BEAT_B +: LOG_BEATS];
  // A beat landing on an already-valid position is a duplicate. This also
  // covers complete slots (every position valid), including the slot being
  // unloaded this very cycle.
  assign w_hit_valid = r_v[w_slot][w_bi];
  assign w_accept    = resp_ack & ~w_hit_valid;
  assign w_beat_vtag = vtags[resp_tid*ADR_W +: ADR_W] & ~LMASK;
  assign w_beat_ptag = resp_adr & ~LMASK;

  // Per-slot status flags
  logic [SLOTS-1:0] w_complete;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot_status
    assign w_complete[gi] = &r_v[gi];
    assign slot_busy[gi]  = |r_v[gi];
  end

  // ---------------------------------------------------------------------
  // Optional bus-error tracking
  // ---------------------------------------------------------------------
`ifdef ICACHE_ACK_ERR_EN
  logic [SLOTS-1:0] r_err;
  logic             w_beat_err;
  assign w_beat_err = resp_err;
`else
  logic             w_unused_err;
  assign w_unused_err = resp_err;
`endif

  // ---------------------------------------------------------------------
  // Round-robin pick of the first complete slot at or after r_rr
  // ---------------------------------------------------------------------
  logic                 w_can_load;
  logic                 w_sel_found;
  logic [LOG_SLOTS-1:0] w_sel;
  logic [LOG_SLOTS-1:0] w_idx;
  logic                 w_load;

  assign w_can_load = ~r_wr_ic | wr_rdy;

  // Scan from the farthest offset down so the nearest complete slot wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel       = r_rr;
    w_idx       = r_rr;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      w_idx = r_rr + LOG_SLOTS'(k);
      if (w_complete[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel       = w_idx;
      end
    end
  end

  assign w_load = w_can_load & w_sel_found;

  // ---------------------------------------------------------------------
  // Slot update: accept new beats, release the slot being unloaded
  // ---------------------------------------------------------------------
  // Accept and release never target the same slot: an accepted beat needs
  // an incomplete slot, a released slot is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) begin
        r_v[s]    <= '0;
        r_data[s] <= '1;
        r_vtag[s] <= '0;
        r_ptag[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        if (w_load && (w_sel == LOG_SLOTS'(s))) begin
          r_v[s]    <= '0;
          r_data[s] <= '1;
        end else if (w_accept && (w_slot == LOG_SLOTS'(s))) begin
          r_v[s][w_bi] <= 1'b1;
`ifdef ICACHE_ACK_ERR_EN
          // Errored beats keep the all-ones fill pattern.
          if (!w_beat_err) begin
            r_data[s][w_bi*BEAT_W +: BEAT_W] <= resp_dat;
          end
`else
          r_data[s][w_bi*BEAT_W +: BEAT_W] <= resp_dat;
`endif
          r_vtag[s] <= w_beat_vtag;
          r_ptag[s] <= w_beat_ptag;
        end
      end
    end
  end

`ifdef ICACHE_ACK_ERR_EN
  // Sticky per-slot error flag, cleared when the slot is unloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        if (w_load && (w_sel == LOG_SLOTS'(s))) begin
          r_err[s] <= 1'b0;
        end else if (w_accept && w_beat_err && (w_slot == LOG_SLOTS'(s))) begin
          r_err[s] <= 1'b1;
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Output register: load a complete line or drain the held one
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ic     <= 1'b0;
      r_line_vtag <= '0;
      r_line_ptag <= '0;
      r_line_data <= '0;
      r_line_err  <= 1'b0;
      r_way       <= '0;
    end else if (w_load) begin
      r_wr_ic     <= 1'b1;
      r_line_vtag <= r_vtag[w_sel];
      r_line_ptag <= r_ptag[w_sel];
      r_line_data <= r_data[w_sel];
`ifdef ICACHE_ACK_ERR_EN
      r_line_err  <= r_err[w_sel];
`else
      r_line_err  <= 1'b0;
`endif
      r_way       <= r_lfsr[LOG_WAYS-1:0];
    end else if (wr_rdy) begin
      r_wr_ic     <= 1'b0;
    end
  end

  // Round-robin pointer advances past the slot just unloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_load) begin
      r_rr <= w_sel + 1'b1;
    end
  end

  // Free-running 17-bit Fibonacci LFSR for victim-way selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 17'h1;
    end else begin
      r_lfsr <= {r_lfsr[15:0], r_lfsr[16] ^ r_lfsr[13]};
    end
  end

  // One-cycle duplicate-beat indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dup <= 1'b0;
    end else begin
      r_dup <= resp_ack & w_hit_valid;
    end
  end

  assign wr_ic     = r_wr_ic;
  assign line_vtag = r_line_vtag;
  assign line_ptag = r_line_ptag;
  assign line_data = r_line_data;
  assign line_err  = r_line_err;
  assign way       = r_way;
  assign dup_beat  = r_dup;

endmodule

// File: tb/tb_icache_line_assembler.sv
// Testbench for icache_line_assembler: directed fills plus randomized
// traffic, checked by a scoreboard fed from a transaction-level model.
module tb_icache_line_assembler;

  localparam int LOG_WAYS     = 2;
  localparam int BEATS        = 2;
  localparam int BEAT_W       = 256;
  localparam int SLOTS        = 2;
  localparam int TID_W        = 4;
  localparam int TID_SLOT_LSB = 2;
  localparam int ADR_W        = 32;
  localparam int NTID         = 2**TID_W;
  localparam int LINE_W       = BEATS * BEAT_W;
  localparam int BEAT_B       = $clog2(BEAT_W / 8);
  localparam logic [31:0] LMASK = (32'd1 << $clog2(LINE_W / 8)) - 32'd1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      resp_ack;
  logic [TID_W-1:0]          resp_tid;
  logic [ADR_W-1:0]          resp_adr;
  logic [BEAT_W-1:0]         resp_dat;
  logic                      resp_err;
  logic [NTID*ADR_W-1:0]     vtags;
  logic                      wr_ic;
  logic                      wr_rdy;
  logic [ADR_W-1:0]          line_vtag;
  logic [ADR_W-1:0]          line_ptag;
  logic [LINE_W-1:0]         line_data;
  logic                      line_err;
  logic [LOG_WAYS-1:0]       way;
  logic                      dup_beat;
  logic [SLOTS-1:0]          slot_busy;

  icache_line_assembler #(
    .LOG_WAYS(LOG_WAYS), .BEATS(BEATS), .BEAT_W(BEAT_W), .SLOTS(SLOTS),
    .TID_W(TID_W), .TID_SLOT_LSB(TID_SLOT_LSB), .ADR_W(ADR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .resp_ack(resp_ack), .resp_tid(resp_tid),
    .resp_adr(resp_adr), .resp_dat(resp_dat), .resp_err(resp_err),
    .vtags(vtags), .wr_ic(wr_ic), .wr_rdy(wr_rdy), .line_vtag(line_vtag),
    .line_ptag(line_ptag), .line_data(line_data), .line_err(line_err),
    .way(way), .dup_beat(dup_beat), .slot_busy(slot_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0] data;
    logic [31:0]       vtag;
    logic [31:0]       ptag;
    logic              err;
    logic [1:0]        way;
  } line_t;

  line_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per slot, a set of received beats and their contents.
  logic [BEATS-1:0]  m_v    [SLOTS];
  logic [BEAT_W-1:0] m_beat [SLOTS][BEATS];
  logic [31:0]       m_vtag [SLOTS];
  logic [31:0]       m_ptag [SLOTS];
  logic              m_err  [SLOTS];
  int                m_rr;
  logic [16:0]       m_lfsr;
  bit                m_full;

  // p_* : prediction for the next edge; e_* : what the DUT shows now.
  bit               p_wr_ic, p_dup, e_wr_ic, e_dup;
  logic [SLOTS-1:0] p_busy, e_busy;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) begin
      m_v[s] = '0;
      m_vtag[s] = '0;
      m_ptag[s] = '0;
      m_err[s] = 1'b0;
      for (int b = 0; b < BEATS; b++) m_beat[s][b] = '1;
    end
    m_rr = 0;
    m_lfsr = 17'h1;
    m_full = 0;
    exp_q.delete();
    p_wr_ic = 0; p_dup = 0; p_busy = '0;
    e_wr_ic = 0; e_dup = 0; e_busy = '0;
  endtask

  // Predict the effect of one clock edge with the given inputs.
  task automatic model_step(input bit ack, input logic [3:0] tid,
                            input logic [31:0] adr, input logic [BEAT_W-1:0] dat,
                            input bit err, input bit rdy);
    int s, bi, sel;
    bit found;
    line_t l;
    s = (int'(tid) >> TID_SLOT_LSB) % SLOTS;
    bi = (int'(adr) >> BEAT_B) % BEATS;
    found = 0;
    sel = 0;
    if (!m_full || rdy) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (!found && m_v[(m_rr + k) % SLOTS] == {BEATS{1'b1}}) begin
          found = 1;
          sel = (m_rr + k) % SLOTS;
        end
      end
    end
    p_dup = 0;
    if (ack) begin
      if (m_v[s][bi]) begin
        p_dup = 1;
      end else begin
        m_v[s][bi] = 1'b1;
`ifdef ICACHE_ACK_ERR_EN
        if (err) m_err[s] = 1'b1;
        else m_beat[s][bi] = dat;
`else
        m_beat[s][bi] = dat;
`endif
        m_vtag[s] = vtags[tid*32 +: 32] & ~LMASK;
        m_ptag[s] = adr & ~LMASK;
      end
    end
    if (found) begin
      for (int b = 0; b < BEATS; b++) l.data[b*BEAT_W +: BEAT_W] = m_beat[sel][b];
      l.vtag = m_vtag[sel];
      l.ptag = m_ptag[sel];
      l.err = m_err[sel];
      l.way = m_lfsr[1:0];
      exp_q.push_back(l);
      m_v[sel] = '0;
      m_err[sel] = 1'b0;
      for (int b = 0; b < BEATS; b++) m_beat[sel][b] = '1;
      m_rr = (sel + 1) % SLOTS;
      m_full = 1;
    end else if (rdy) begin
      m_full = 0;
    end
    m_lfsr = {m_lfsr[15:0], m_lfsr[16] ^ m_lfsr[13]};
    p_wr_ic = m_full;
    for (int k = 0; k < SLOTS; k++) p_busy[k] = (m_v[k] != '0);
  endtask

  // Drive one cycle of inputs (called just after a rising edge).
  task automatic cyc(input bit ack, input logic [3:0] tid, input logic [31:0] adr,
                     input logic [BEAT_W-1:0] dat, input bit err, input bit rdy);
    e_wr_ic = p_wr_ic;
    e_dup = p_dup;
    e_busy = p_busy;
    resp_ack = ack;
    resp_tid = tid;
    resp_adr = adr;
    resp_dat = dat;
    resp_err = err;
    wr_rdy = rdy;
    model_step(ack, tid, adr, dat, err, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 4'h0, 32'h0, '0, 0, rdy);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    resp_ack = 1'b0;
    wr_rdy = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [BEAT_W-1:0] rnd_beat();
    logic [BEAT_W-1:0] d;
    for (int i = 0; i < BEAT_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: compare visible state and pop lines as the cache accepts them.
  initial begin
    forever begin
      @(negedge clk);
      chk("wr_ic", LINE_W'(wr_ic), LINE_W'(e_wr_ic));
      chk("dup_beat", LINE_W'(dup_beat), LINE_W'(e_dup));
      chk("slot_busy", LINE_W'(slot_busy), LINE_W'(e_busy));
      if (wr_ic === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_line: got ptag %h expected no line at %0t", line_ptag, $time);
        end else begin
          chk("line_data", line_data, exp_q[0].data);
          chk("line_vtag", LINE_W'(line_vtag), LINE_W'(exp_q[0].vtag));
          chk("line_ptag", LINE_W'(line_ptag), LINE_W'(exp_q[0].ptag));
          chk("line_err", LINE_W'(line_err), LINE_W'(exp_q[0].err));
          chk("way", LINE_W'(way), LINE_W'(exp_q[0].way));
          if (wr_rdy === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  logic [BEAT_W-1:0] da, db;

  initial begin
    rst_n = 1'b0;
    resp_ack = 1'b0;
    resp_tid = '0;
    resp_adr = '0;
    resp_dat = '0;
    resp_err = 1'b0;
    wr_rdy = 1'b0;
    for (int t = 0; t < NTID; t++) vtags[t*32 +: 32] = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1);

    // 1: in-order fill on slot 1
    da = rnd_beat(); db = rnd_beat();
    cyc(1, 4'h4, 32'h1000, da, 0, 1);
    cyc(1, 4'h4, 32'h1020, db, 0, 1);
    idle(3, 1);

    // 2: out-of-order interleave across two slots
    cyc(1, 4'h1, 32'h2020, rnd_beat(), 0, 1);
    cyc(1, 4'h5, 32'h3000, rnd_beat(), 0, 1);
    cyc(1, 4'h2, 32'h2000, rnd_beat(), 0, 1);
    cyc(1, 4'h6, 32'h3020, rnd_beat(), 0, 1);
    idle(3, 1);

    // 3: backpressure with two complete slots
    cyc(1, 4'h0, 32'h4000, rnd_beat(), 0, 0);
    cyc(1, 4'h0, 32'h4020, rnd_beat(), 0, 0);
    cyc(1, 4'h4, 32'h5020, rnd_beat(), 0, 0);
    cyc(1, 4'h4, 32'h5000, rnd_beat(), 0, 0);
    idle(5, 0);
    idle(4, 1);

    // 4: duplicate beat keeps first data
    da = rnd_beat(); db = rnd_beat();
    cyc(1, 4'h0, 32'h6000, da, 0, 1);
    cyc(1, 4'h0, 32'h6000, db, 0, 1);
    cyc(1, 4'h0, 32'h6020, rnd_beat(), 0, 1);
    idle(3, 1);

    // 5: reset mid-fill
    cyc(1, 4'h0, 32'h7000, rnd_beat(), 0, 1);
    pulse_reset();
    cyc(1, 4'h0, 32'h7020, rnd_beat(), 0, 1);
    idle(4, 1);
    pulse_reset();
    idle(1, 1);

    // 6: errored beat
    cyc(1, 4'h4, 32'h8020, rnd_beat(), 1, 1);
    cyc(1, 4'h4, 32'h8000, rnd_beat(), 0, 1);
    idle(3, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom;
      cyc(($urandom_range(0, 9) < 6), 4'($urandom), a, rnd_beat(),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 999) == 0) pulse_reset();
    end

    // Drain: every complete line should be delivered and nothing left over.
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < SLOTS; s++) begin
        for (int b = 0; b < BEATS; b++) begin
          cyc(1, 4'(s << TID_SLOT_LSB), 32'h9000 | 32'(b << BEAT_B), rnd_beat(), 0, 1);
        end
      end
    end
    idle(8, 1);
    chk("queue_empty", LINE_W'(exp_q.size()), LINE_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
